// File: rtl/adc_scan_selector.sv
// ADC channel selector configured over the UART byte stream, with fixed and
// mask-scan modes, error/timeout reporting and glitch-free sample clock gating.
module adc_scan_selector #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_ADC      = 4,
    parameter int unsigned DEFAULT_CH = 0,
    parameter int unsigned TIMEOUT    = 1000000,
    localparam int unsigned CH_W      = $clog2(N_ADC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     activate,
    output logic                     done,
    output logic                     err,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic [N_ADC*WIDTH-1:0]   adc_data_in,
    output logic [N_ADC-1:0]         adc_clk_out,
    output logic [WIDTH-1:0]         adc_data,
    input  logic                     adc_clk,
    output logic [CH_W-1:0]          adc_sel,
    output logic                     scan_mode
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_MASK  = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [N_ADC-1:0] RST_MASK = N_ADC'(1) << DEFAULT_CH;

    logic [2:0]        state, state_d;
    logic              done_d, err_d, scan_d, stg_scan, stg_scan_d;
    logic [CH_W-1:0]   sel_d, stg_sel, stg_sel_d;
    logic [N_ADC-1:0]  mask, mask_d, stg_mask, stg_mask_d;
    logic [TW-1:0]     tcnt, tcnt_d;
    logic              adc_clk_q;

    logic [WIDTH-1:0]  ch_data [N_ADC];
    logic [CH_W-1:0]   scan_low, scan_above, scan_nxt, rx_low;
    logic              has_above;
    logic [N_ADC-1:0]  rx_mask;
    logic [6:0]        ch;
    logic              ch_ok, tmo, adc_fall;
    logic [CH_W-1:0]   ch_idx;

    for (genvar g = 0; g < int'(N_ADC); g++) begin : g_unpack
        assign ch_data[g] = adc_data_in[g*WIDTH +: WIDTH];
    end

    // Output mux and clock gating follow the registered selection only
    always_comb begin
        adc_data    = '0;
        adc_clk_out = '0;
        for (int j = 0; j < int'(N_ADC); j++) begin
            if (adc_sel == CH_W'(j)) begin
                adc_data               = ch_data[CH_W'(j)];
                adc_clk_out[CH_W'(j)]  = adc_clk;
            end
        end
    end

    // Next enabled channel above the current one, else wrap to the lowest
    always_comb begin
        scan_low   = '0;
        scan_above = '0;
        has_above  = 1'b0;
        rx_low     = '0;
        for (int j = int'(N_ADC) - 1; j >= 0; j--) begin
            if (mask[CH_W'(j)]) begin
                scan_low = CH_W'(j);
                if (j > int'(adc_sel)) begin
                    scan_above = CH_W'(j);
                    has_above  = 1'b1;
                end
            end
            if (rx_mask[CH_W'(j)]) begin
                rx_low = CH_W'(j);
            end
        end
        scan_nxt = has_above ? scan_above : scan_low;
    end

    assign rx_mask  = rx_data[N_ADC-1:0];
    assign ch       = rx_data[6:0];
    assign ch_ok    = (ch != 7'd0) && (ch <= 7'(N_ADC));
    assign ch_idx   = CH_W'(ch - 7'd1);
    assign tmo      = (tcnt == TW'(TIMEOUT - 1));
    assign adc_fall = adc_clk_q & ~adc_clk;

    always_comb begin
        state_d    = state;
        done_d     = done;
        err_d      = err;
        sel_d      = adc_sel;
        mask_d     = mask;
        scan_d     = scan_mode;
        stg_sel_d  = stg_sel;
        stg_mask_d = stg_mask;
        stg_scan_d = stg_scan;
        tcnt_d     = tcnt;

        if (scan_mode && adc_fall) begin
            sel_d = scan_nxt;
        end

        case (state)
            S_IDLE: begin
                done_d = 1'b0;
                if (activate) begin
                    err_d   = 1'b0;
                    tcnt_d  = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!activate) begin
                    state_d = S_IDLE;
                end else if (rx_ready) begin
                    tcnt_d = '0;
                    if (rx_data[7]) begin
                        state_d = S_MASK;
                    end else if (ch_ok) begin
                        stg_sel_d  = ch_idx;
                        stg_mask_d = N_ADC'(1) << ch_idx;
                        stg_scan_d = 1'b0;
                        state_d    = S_APPLY;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_MASK: begin
                if (!activate) begin
                    state_d = S_IDLE;
                end else if (rx_ready) begin
                    tcnt_d = '0;
                    if (rx_mask != '0) begin
                        stg_sel_d  = rx_low;
                        stg_mask_d = rx_mask;
                        stg_scan_d = 1'b1;
                        state_d    = S_APPLY;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_APPLY: begin
                // Commit only while the strobe is low; overrides a same-cycle scan step
                if (!adc_clk) begin
                    sel_d   = stg_sel;
                    mask_d  = stg_mask;
                    scan_d  = stg_scan;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (!activate) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            adc_sel   <= CH_W'(DEFAULT_CH);
            mask      <= RST_MASK;
            scan_mode <= 1'b0;
            stg_sel   <= CH_W'(DEFAULT_CH);
            stg_mask  <= RST_MASK;
            stg_scan  <= 1'b0;
            tcnt      <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            state     <= state_d;
            done      <= done_d;
            err       <= err_d;
            adc_sel   <= sel_d;
            mask      <= mask_d;
            scan_mode <= scan_d;
            stg_sel   <= stg_sel_d;
            stg_mask  <= stg_mask_d;
            stg_scan  <= stg_scan_d;
            tcnt      <= tcnt_d;
            adc_clk_q <= adc_clk;
        end
    end

endmodule

// File: tb/tb_adc_scan_selector.sv
// Randomized scoreboard bench for adc_scan_selector: a driver pushes expected
// outcomes, a negedge monitor pops and compares them as the DUT presents them.
module tb_adc_scan_selector;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned DEF = 0;
    localparam int unsigned TMO = 16;

    logic          clk;
    logic          rst;
    logic          activate;
    logic          done;
    logic          err;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [N*W-1:0] adc_data_in;
    logic [N-1:0]  adc_clk_out;
    logic [W-1:0]  adc_data;
    logic          adc_clk;
    logic [1:0]    adc_sel;
    logic          scan_mode;

    adc_scan_selector #(
        .WIDTH(W), .N_ADC(N), .DEFAULT_CH(DEF), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .activate(activate), .done(done), .err(err),
        .rx_data(rx_data), .rx_ready(rx_ready), .adc_data_in(adc_data_in),
        .adc_clk_out(adc_clk_out), .adc_data(adc_data), .adc_clk(adc_clk),
        .adc_sel(adc_sel), .scan_mode(scan_mode)
    );

    typedef struct {
        bit e;
        int s;
        bit sc;
    } exp_t;

    exp_t done_q[$];
    int   scan_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference configuration, as the specification describes it
    int       cfg_sel;
    bit [3:0] cfg_mask;
    bit       cfg_scan;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int nxt(input int s, input bit [3:0] m);
        for (int k = 1; k < int'(N); k++) begin
            int c;
            c = (s + k) % int'(N);
            if (m[c]) return c;
        end
        return s;
    endfunction

    function automatic int lowest(input bit [3:0] m);
        for (int c = 0; c < int'(N); c++) begin
            if (m[c]) return c;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        adc_data_in = $urandom;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse(input int h, input int l);
        adc_clk = 1'b1;
        repeat (h) step();
        adc_clk = 1'b0;
        if (cfg_scan) cfg_sel = nxt(cfg_sel, cfg_mask);
        scan_q.push_back(cfg_sel);
        repeat (l) step();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic do_cfg(input logic [7:0] b0, input logic [7:0] b1, input bit pre, input bit hi);
        bit       ok;
        int       nsel;
        bit [3:0] nmask;
        bit       nscan;
        int       n;
        exp_t     x;
        activate = 1'b1;
        step();
        if (pre) pulse(1, 1);
        repeat ($urandom_range(0, 2)) step();
        ok = 1'b0; nsel = cfg_sel; nmask = cfg_mask; nscan = cfg_scan;
        if (b0[7]) begin
            send(b0);
            repeat ($urandom_range(0, 2)) step();
            if (b1[3:0] != 4'd0) begin
                ok = 1'b1; nmask = b1[3:0]; nsel = lowest(b1[3:0]); nscan = 1'b1;
            end
            if (hi) adc_clk = 1'b1;
            send(b1);
        end else begin
            if (int'(b0[6:0]) >= 1 && int'(b0[6:0]) <= int'(N)) begin
                ok = 1'b1; nsel = int'(b0[6:0]) - 1; nmask = 4'b0001 << nsel; nscan = 1'b0;
            end
            if (hi) adc_clk = 1'b1;
            send(b0);
        end
        x.e = !ok;
        x.s = ok ? nsel : cfg_sel;
        x.sc = ok ? nscan : cfg_scan;
        done_q.push_back(x);
        if (hi) begin
            step();
            adc_clk = 1'b0;
            if (ok) begin
                cfg_sel = nsel; cfg_mask = nmask; cfg_scan = nscan;
            end else if (cfg_scan) begin
                cfg_sel = nxt(cfg_sel, cfg_mask);
            end
            scan_q.push_back(cfg_sel);
        end else if (ok) begin
            cfg_sel = nsel; cfg_mask = nmask; cfg_scan = nscan;
        end
        wait_done(n);
        chk("done_latency", n, ok ? 1 : 0);
        if ($urandom_range(0, 1) == 1) send(8'($urandom));
        activate = 1'b0;
        step();
        chk("done_drop", int'(done), 0);
        chk("err_hold", int'(err), ok ? 0 : 1);
    endtask

    task automatic do_tmo(input bit two);
        int   n;
        exp_t x;
        activate = 1'b1;
        step();
        if (two) send(8'h80);
        x.e = 1'b1; x.s = cfg_sel; x.sc = cfg_scan;
        done_q.push_back(x);
        wait_done(n);
        chk("tmo_latency", n, int'(TMO));
        activate = 1'b0;
        step();
        chk("tmo_done_drop", int'(done), 0);
    endtask

    // Monitor: pops expectations when the DUT presents a result
    int  mon_sel;
    bit  prev_clk, pend, done_prev;
    always @(negedge clk) begin
        exp_t     x;
        int       e;
        bit [3:0] ev;
        if (!rst) begin
            mon_sel = DEF; prev_clk = 1'b0; pend = 1'b0; done_prev = 1'b0;
        end else begin
            if (pend) begin
                if (scan_q.size() == 0) begin
                    chk("scan_q_nonempty", 0, 1);
                end else begin
                    e = scan_q.pop_front();
                    chk("scan_sel", int'(adc_sel), e);
                    mon_sel = e;
                end
            end
            if (done && !done_prev) begin
                if (done_q.size() == 0) begin
                    chk("done_q_nonempty", 0, 1);
                end else begin
                    x = done_q.pop_front();
                    chk("cfg_err", int'(err), int'(x.e));
                    chk("cfg_sel", int'(adc_sel), x.s);
                    chk("cfg_scan", int'(scan_mode), int'(x.sc));
                    mon_sel = x.s;
                end
            end
            ev = adc_clk ? (4'b0001 << mon_sel) : 4'b0000;
            chk("clk_out", int'(adc_clk_out), int'(ev));
            chk("adc_data", int'(adc_data), int'(adc_data_in[mon_sel*W +: W]));
            pend = prev_clk && !adc_clk;
            prev_clk = adc_clk;
            done_prev = done;
        end
    end

    initial begin
        logic [7:0] b0, b1;
        rst = 1'b0; activate = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; adc_clk = 1'b0;
        adc_data_in = $urandom;
        cfg_sel = DEF; cfg_mask = 4'b0001 << DEF; cfg_scan = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("rst_sel", int'(adc_sel), int'(DEF));
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_scan", int'(scan_mode), 0);
        pulse(2, 2);
        send(8'h02);
        pulse(1, 1);

        do_cfg(8'h03, 8'h00, 1'b0, 1'b0);
        pulse(2, 1);
        do_cfg(8'h05, 8'h00, 1'b0, 1'b0);
        do_cfg(8'h00, 8'h00, 1'b0, 1'b0);
        do_cfg(8'h80, 8'h0A, 1'b0, 1'b0);
        repeat (4) pulse(2, 2);
        do_cfg(8'h02, 8'h00, 1'b0, 1'b1);
        pulse(1, 1);
        do_cfg(8'h80, 8'hF0, 1'b0, 1'b0);
        do_cfg(8'h80, 8'h0E, 1'b1, 1'b0);
        pulse(1, 2);
        do_tmo(1'b1);
        do_tmo(1'b0);
        pulse(2, 1);

        for (int i = 0; i < 40; i++) begin
            b0 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) b0[6:0] = 7'($urandom_range(0, 6));
            b1 = 8'($urandom);
            if ($urandom_range(0, 4) == 0) b1 = b1 & 8'hF0;
            do_cfg(b0, b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 4)) pulse($urandom_range(1, 3), $urandom_range(1, 2));
            if ($urandom_range(0, 2) == 0) send(8'($urandom));
        end

        // Early activate drop while waiting for the mask byte
        do_cfg(8'h80, 8'h05, 1'b0, 1'b0);
        activate = 1'b1;
        step();
        send(8'h80);
        step();
        activate = 1'b0;
        step();
        step();
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_sel", int'(adc_sel), cfg_sel);
        chk("abort_scan", int'(scan_mode), int'(cfg_scan));

        // Asynchronous reset in the middle of a scan command
        activate = 1'b1;
        step();
        send(8'h80);
        step();
        rst = 1'b0;
        #1;
        chk("arst_sel", int'(adc_sel), int'(DEF));
        chk("arst_scan", int'(scan_mode), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        cfg_sel = DEF; cfg_mask = 4'b0001 << DEF; cfg_scan = 1'b0;
        activate = 1'b0;
        step();
        rst = 1'b1;
        step();
        pulse(1, 1);
        do_cfg(8'h04, 8'h00, 1'b0, 1'b0);

        repeat (4) step();
        chk("done_q_empty", done_q.size(), 0);
        chk("scan_q_empty", scan_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
